sr_sipo_deframer: RTL
=====================

# sr_sipo_deframer

Serial-in/parallel-out receiver that sits directly downstream of the 8-bit PISO shift register, consuming its serial bit stream and reassembling parallel words. Words are aligned by a start-of-frame strobe, shifted in MSB first, and presented on a single-entry output buffer with a valid/ready handshake. Overrun and framing errors are flagged so the upstream PISO and its controller can be checked end to end.

## Interface
Parameters:
- WIDTH, 8: bits per word; must be ≥2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- sin  in  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  in  1  qualifies sin for this cycle.
- sin_sof  in  1  start-of-frame; meaningful only with sin_valid=1; marks sin as the MSB of a new word.
- dout  out  [WIDTH:1]  assembled word; dout[WIDTH] is the first bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  downstream accepts dout when dout_valid=1.
- overrun  out  1  sticky; a completed word was dropped because the buffer was full.
- frame_err  out  1  one-cycle pulse; sin_sof arrived mid-word.

## Operation
- States: HUNT (unaligned, after reset) and SHIFT (aligned). Bit counter cnt, range 0..WIDTH-1, counts bits held in the shift register.
- HUNT: sin_valid=1 with sin_sof=0 is ignored. sin_valid=1 with sin_sof=1 loads the bit, sets cnt=1 and moves to SHIFT.
- SHIFT: each sin_valid=1 shifts left: sh <= {sh[WIDTH-1:1], sin}, cnt+1.
- Completion: when the accepted bit is the WIDTH-th bit (cnt==WIDTH-1), the word {sh[WIDTH-1:1], sin} goes to the output buffer, cnt returns to 0 and the state stays SHIFT. The next valid bit starts a new word with or without sin_sof, so back-to-back words need no gap.
- sin_sof with cnt==0 in SHIFT: normal start, no error.
- sin_sof with cnt≠0 in SHIFT:
  - frame_err pulses for one cycle and the partial word is discarded.
  - The sof bit becomes bit 1 of a new word (cnt=1).
- Output buffer:
  - A handshake (dout_valid & dout_ready) clears dout_valid unless a new word completes in the same cycle.
  - If a new word completes in the same cycle as the handshake, dout loads the new word and dout_valid stays 1 with no overrun.
  - If a word completes while dout_valid=1 and dout_ready=0, the new word is dropped, dout is unchanged and overrun sets.
- overrun clears only on reset.
- dout holds its last value after it is consumed.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State HUNT, cnt=0, shift register 0.
  - dout=0, dout_valid=0, overrun=0, frame_err=0.
  - Any partial word or buffered word is lost.
- Latency: dout and dout_valid update on the same rising edge that samples the last bit, so they are visible one cycle after that bit is presented.
- Throughput: one bit per cycle, one word per WIDTH cycles sustained.
- frame_err is registered: high exactly the cycle after the offending edge.
- dout_ready is sampled on the clock edge. The block has no combinational input-to-output paths.

## Structure
- Shared package sr_pkg:
  - State typedef (HUNT, SHIFT).
  - Default-width constant SR_WIDTH=8, shared with the PISO.
- cnt width is $clog2(WIDTH).
- One sub-module, sr_sipo_core, holding the shift register and bit counter with load, shift, clear and done outputs. The top level owns the FSM, the output buffer and the flags.

## Test plan
- Reset mid-word: assert reset after 4 bits, release, then send a fresh sof word 8'h22 → only 8'h22 appears; no errors.
- Basic frame, 8'hA1 = 10100001:
  - Stimulus: sin_sof on the first bit, then 8 consecutive valid bits MSB first, dout_ready=1.
  - Response: dout=8'hA1 with dout_valid high for exactly 1 cycle, starting the cycle after the 8th bit.
- Back-to-back without sof:
  - Stimulus: 16 continuous bits for 8'h1E then 8'h6F, with sin_valid gaps inserted in the second word.
  - Response: two words 8'h1E then 8'h6F, in order.
- Frame error:
  - Stimulus: sin_sof at bit 3 of a word, then 8 bits of 8'h0A.
  - Response: frame_err high for 1 cycle; next dout=8'h0A.
- Overrun and simultaneous handshake:
  - With dout_ready=0, two words (8'h10, 8'h2E) → dout=8'h10 and overrun=1 (sticky).
  - With dout_ready=1 asserted exactly on the completion edge of 8'h03 → dout=8'h03, dout_valid stays 1, no new overrun.
- HUNT filtering: 5 valid bits without sof after reset, then an sof word 8'h24 → only 8'h24 appears; no frame_err.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register family (PISO transmitter / SIPO deframer).
package sr_pkg;

    localparam int SR_WIDTH = 8;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } sr_state_e;

endpackage

// File: rtl/sr_sipo_core.sv
// Shift register and bit counter for the SIPO deframer; word_o/done_o describe the word
// completed by the bit presented this cycle.
module sr_sipo_core
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sin_i,
    input  logic                       load_i,
    input  logic                       shift_i,
    input  logic                       clear_i,
    output logic [$clog2(WIDTH)-1:0]   cnt_o,
    output logic [WIDTH:1]             word_o,
    output logic                       done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Only the WIDTH-1 oldest bits are stored; the final bit comes straight from sin_i.
    logic [WIDTH-1:1] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign word_o = {sh_q, sin_i};
    assign done_o = shift_i && (cnt_q == LAST);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            sh_d    = '0;
            sh_d[1] = sin_i;
            cnt_d   = ONE;
        end else if (shift_i) begin
            for (int unsigned i = WIDTH - 1; i >= 2; i--) begin
                sh_d[i] = sh_q[i-1];
            end
            sh_d[1] = sin_i;
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_sipo_deframer.sv
// SIPO deframer: aligns on start-of-frame, assembles MSB-first words and hands them out
// through a single-entry valid/ready buffer with sticky overrun and pulsed framing error.
module sr_sipo_deframer
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sof,
    output logic [WIDTH:1]   dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);

    sr_state_e       state_q, state_d;
    logic [WIDTH:1]  dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;

    logic            load, shift, clear, done;
    logic [CW-1:0]   cnt;
    logic [WIDTH:1]  word;

    sr_sipo_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .sin_i   (sin),
        .load_i  (load),
        .shift_i (shift),
        .clear_i (clear),
        .cnt_o   (cnt),
        .word_o  (word),
        .done_o  (done)
    );

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        clear        = 1'b0;

        // Any sof restarts the word at bit 1; it is only an error if bits were pending.
        case (state_q)
            HUNT: begin
                if (sin_valid && sin_sof) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    clear = 1'b1;
                end
            end
            SHIFT: begin
                if (sin_valid && sin_sof) begin
                    load        = 1'b1;
                    frame_err_d = (cnt != '0);
                end else if (sin_valid) begin
                    shift = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule
